boot_loader_ctrl: RTL and testbench

Instruction-memory controller that sits between the program loader stream and the CPU fetch port. It owns the instruction RAM and holds the CPU in reset while a program is streamed in. After the final word it keeps the CPU in reset for a fixed number of cycles, then releases it and serves `inst` for each `pc`. It sequences the CPU's reset and shares the instruction store between the loader (write) and the CPU (read).

---
 rtl/boot_loader_ctrl.sv | 141 ++++++++++++++
 tb/tb_boot_loader_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: owns the instruction RAM and streams a program into it
// while the CPU is held in reset. After the final word it holds the CPU in
// reset for RST_CYCLES cycles, then releases it and serves fetches.
// A fetch outside the loaded image returns NOP_INST.

`ifndef START_ADRS
`define START_ADRS 32'h0000_1000
`endif

module boot_loader_ctrl #(
    parameter int          DEPTH      = 1024,
    parameter logic [31:0] START_ADRS = `START_ADRS,
    parameter int          RST_CYCLES = 5,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic                    clk_cpu,
    input  logic                    reset_n,
    input  logic                    ld_start,
    input  logic                    ld_valid,
    input  logic [31:0]             ld_data,
    input  logic                    ld_last,
    output logic                    ld_ready,
    input  logic [31:0]             pc,
    output logic [31:0]             inst,
    output logic                    cpu_reset,
    output logic                    busy,
    output logic                    load_err,
    output logic [$clog2(DEPTH):0]  words_loaded
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(RST_CYCLES) + 1;
    localparam logic [WW-1:0] FULL_CNT  = WW'(DEPTH);
    localparam logic [CW-1:0] HOLD_INIT = CW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2,
        S_RUN  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [WW-1:0]   r_words_loaded;
    logic            r_load_err;
    logic [CW-1:0]   r_hold_cnt;
    logic [31:0]     r_mem [DEPTH];

    logic            w_accept;
    logic            w_store;
    logic            w_load_entry;
    logic            w_hit;
    logic [31:0]     w_idx;

    // A word is taken only while loading; once the RAM is full it is dropped.
    assign w_accept     = (r_state == S_LOAD) && ld_valid;
    assign w_store      = w_accept && (r_words_loaded != FULL_CNT);
    assign w_load_entry = (r_state != S_LOAD) && (w_next == S_LOAD);

    // Byte address to word index relative to the RAM base; pc[1:0] drop out.
    assign w_idx = (pc - START_ADRS) >> 2;

    // State register.
    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; ld_start is only honoured in IDLE and RUN.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (ld_start) w_next = S_LOAD;
            S_LOAD:  if (w_accept && ld_last) w_next = S_HOLD;
            S_HOLD:  if (r_hold_cnt == '0) w_next = S_RUN;
            S_RUN:   if (ld_start) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state, plus the masked fetch path.
    always_comb begin
        ld_ready  = 1'b0;
        busy      = 1'b0;
        cpu_reset = 1'b1;
        case (r_state)
            S_LOAD: begin
                ld_ready = 1'b1;
                busy     = 1'b1;
            end
            S_HOLD:  busy      = 1'b1;
            S_RUN:   cpu_reset = 1'b0;
            default: ;
        endcase
        w_hit = (r_state == S_RUN) && (pc >= START_ADRS) &&
                (w_idx < {{(32-WW){1'b0}}, r_words_loaded});
        inst  = w_hit ? r_mem[w_idx[AW-1:0]] : NOP_INST;
    end

    // Word count and overflow flag; both restart on every entry into LOAD.
    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            r_words_loaded <= '0;
            r_load_err     <= 1'b0;
        end else if (w_load_entry) begin
            r_words_loaded <= '0;
            r_load_err     <= 1'b0;
        end else if (w_store) begin
            r_words_loaded <= r_words_loaded + WW'(1);
        end else if (w_accept) begin
            r_load_err     <= 1'b1;
        end
    end

    // Hold down-counter: primed throughout LOAD, counts to zero in HOLD.
    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            r_hold_cnt <= '0;
        end else if (r_state == S_LOAD) begin
            r_hold_cnt <= HOLD_INIT;
        end else if ((r_state == S_HOLD) && (r_hold_cnt != '0)) begin
            r_hold_cnt <= r_hold_cnt - CW'(1);
        end
    end

    // Instruction RAM write port; contents survive reset and reloads.
    always_ff @(posedge clk_cpu) begin
        if (w_store) begin
            r_mem[r_words_loaded[AW-1:0]] <= ld_data;
        end
    end

    assign words_loaded = r_words_loaded;
    assign load_err     = r_load_err;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Testbench for boot_loader_ctrl: behavioural model plus literal spot checks.
module tb_boot_loader_ctrl;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          RSTC  = 5;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          WW    = $clog2(DEPTH) + 1;

    logic          clk_cpu  = 1'b0;
    logic          reset_n  = 1'b1;
    logic          ld_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_last  = 1'b0;
    logic [31:0]   ld_data  = '0;
    logic [31:0]   pc       = '0;
    logic          ld_ready, cpu_reset, busy, load_err;
    logic [31:0]   inst;
    logic [WW-1:0] words_loaded;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    boot_loader_ctrl #(
        .DEPTH      (DEPTH),
        .START_ADRS (BASE),
        .RST_CYCLES (RSTC),
        .NOP_INST   (NOP)
    ) dut (
        .clk_cpu      (clk_cpu),
        .reset_n      (reset_n),
        .ld_start     (ld_start),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_last      (ld_last),
        .ld_ready     (ld_ready),
        .pc           (pc),
        .inst         (inst),
        .cpu_reset    (cpu_reset),
        .busy         (busy),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk_cpu = ~clk_cpu;

    // Behavioural model: what the controller is doing, not how.
    logic [31:0] m_mem [DEPTH];
    int          m_wl      = 0;
    bit          m_err     = 1'b0;
    bit          m_loading = 1'b0;
    bit          m_running = 1'b0;
    int          m_hold    = 0;

    always @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            m_loading = 1'b0; m_running = 1'b0; m_hold = 0; m_wl = 0; m_err = 1'b0;
        end else if (m_loading) begin
            if (ld_valid) begin
                if (m_wl < DEPTH) begin
                    m_mem[m_wl] = ld_data;
                    m_wl++;
                end else begin
                    m_err = 1'b1;
                end
                if (ld_last) begin
                    m_loading = 1'b0;
                    m_hold    = RSTC;
                end
            end
        end else if (m_hold > 0) begin
            m_hold--;
            if (m_hold == 0) m_running = 1'b1;
        end else if (ld_start) begin
            m_loading = 1'b1; m_running = 1'b0; m_wl = 0; m_err = 1'b0;
        end
    end

    function automatic logic [31:0] m_inst(input logic [31:0] a);
        logic [31:0] off;
        int idx;
        off = a - BASE;
        idx = int'(off >> 2);
        if (m_running && a >= BASE && idx < m_wl) return m_mem[idx];
        return NOP;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare every output against the model once per cycle.
    always @(negedge clk_cpu) begin
        if (cmp_en) begin
            check("cpu_reset",    32'(cpu_reset),    32'(!m_running));
            check("ld_ready",     32'(ld_ready),     32'(m_loading));
            check("busy",         32'(busy),         32'(m_loading || m_hold > 0));
            check("load_err",     32'(load_err),     32'(m_err));
            check("words_loaded", 32'(words_loaded), 32'(m_wl));
            check("inst",         inst,              m_inst(pc));
        end
    end

    task automatic step();
        @(negedge clk_cpu);
        #1;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        step();
        ld_start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last);
        ld_valid = 1'b1; ld_data = d; ld_last = last;
        step();
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    // Count cycles with cpu_reset high after the last accept; loader noise
    // during HOLD must have no effect.
    task automatic wait_run(output int hi);
        hi = 0;
        for (int i = 0; i < 20; i++) begin
            if (!cpu_reset) break;
            hi++;
            ld_valid = 1'($urandom); ld_data = $urandom; ld_start = 1'($urandom);
            step();
        end
        ld_valid = 1'b0; ld_start = 1'b0;
    endtask

    task automatic fetch(input string nm, input logic [31:0] a, input logic [31:0] exp);
        pc = a;
        #1;
        check(nm, inst, exp);
    endtask

    initial begin
        int hi;
        int len;
        logic [31:0] w;

        // Reset held for 3 cycles
        #1 reset_n = 1'b0;
        cmp_en = 1'b1;
        ld_valid = 1'b1; ld_data = 32'hDEAD_BEEF;
        repeat (3) step();
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_ld_ready",  32'(ld_ready),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_load_err",  32'(load_err),  32'd0);
        check("rst_wl",        32'(words_loaded), 32'd0);
        fetch("rst_inst_base", BASE, NOP);
        fetch("rst_inst_zero", 32'h0, NOP);
        reset_n = 1'b1;
        repeat (2) step();          // ld_valid still high in IDLE: ignored
        ld_valid = 1'b0;
        check("idle_wl", 32'(words_loaded), 32'd0);

        // Basic 4-word load
        start_load();
        check("load_ready", 32'(ld_ready), 32'd1);
        send_word(32'h1111_1111, 1'b0);
        send_word(32'h2222_2222, 1'b0);
        send_word(32'h3333_3333, 1'b0);
        send_word(32'h4444_4444, 1'b1);
        check("basic_wl", 32'(words_loaded), 32'd4);
        wait_run(hi);
        check("basic_hold", 32'(hi), 32'd5);
        fetch("basic_pc8",   BASE + 32'd8,  32'h3333_3333);
        fetch("basic_pc16",  BASE + 32'd16, NOP);
        fetch("basic_pc9",   BASE + 32'd9,  32'h3333_3333);
        fetch("basic_below", BASE - 32'd4,  NOP);
        step();

        // Backpressure gaps: valid 1,0,0,1,1 carrying 3 words
        start_load();
        send_word(32'hA000_0001, 1'b0);
        ld_data = 32'hBAD0_0000; step(); step();
        send_word(32'hA000_0002, 1'b0);
        send_word(32'hA000_0003, 1'b1);
        wait_run(hi);
        check("bp_hold", 32'(hi), 32'd5);
        check("bp_wl",   32'(words_loaded), 32'd3);
        fetch("bp_w0", BASE,           32'hA000_0001);
        fetch("bp_w1", BASE + 32'd4,   32'hA000_0002);
        fetch("bp_w2", BASE + 32'd8,   32'hA000_0003);
        fetch("bp_w3", BASE + 32'd12,  NOP);
        step();

        // Overflow: 6 words into a 4-deep RAM
        start_load();
        for (int i = 0; i < 6; i++) send_word(32'hC000_0000 + 32'(i), 1'(i == 5));
        check("ovf_wl",  32'(words_loaded), 32'd4);
        check("ovf_err", 32'(load_err),     32'd1);
        wait_run(hi);
        check("ovf_hold", 32'(hi), 32'd5);
        fetch("ovf_w0", BASE,          32'hC000_0000);
        fetch("ovf_w3", BASE + 32'd12, 32'hC000_0003);
        step();

        // Reload from RUN with 2 words
        fetch("rl_before", BASE + 32'd12, 32'hC000_0003);
        start_load();
        check("rl_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rl_inst",      inst,           NOP);
        check("rl_err_clr",   32'(load_err),  32'd0);
        send_word(32'h5555_0000, 1'b0);
        send_word(32'h5555_0001, 1'b1);
        wait_run(hi);
        check("rl_wl", 32'(words_loaded), 32'd2);
        fetch("rl_pc12", BASE + 32'd12, NOP);
        fetch("rl_pc4",  BASE + 32'd4,  32'h5555_0001);
        step();

        // Asynchronous abort mid-LOAD
        start_load();
        send_word(32'h7777_0000, 1'b0);
        send_word(32'h7777_0001, 1'b0);
        ld_valid = 1'b1; ld_data = 32'h7777_0002;
        #2 reset_n = 1'b0;
        #1;
        check("abort_wl",    32'(words_loaded), 32'd0);
        check("abort_busy",  32'(busy),         32'd0);
        check("abort_ready", 32'(ld_ready),     32'd0);
        ld_valid = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (3) step();
        check("abort_idle", 32'(busy), 32'd0);
        start_load();
        send_word(32'hCAFE_F00D, 1'b1);
        wait_run(hi);
        check("abort_hold", 32'(hi), 32'd5);
        check("abort_rl_wl", 32'(words_loaded), 32'd1);
        fetch("abort_w0", BASE, 32'hCAFE_F00D);
        step();

        // Randomized loads and fetches against the model
        for (int it = 0; it < 30; it++) begin
            start_load();
            len = $urandom_range(1, 6);
            for (int k = 0; k < len; k++) begin
                while ($urandom_range(0, 2) == 0) begin
                    ld_valid = 1'b0; ld_data = $urandom; ld_start = 1'($urandom);
                    pc = BASE + 32'($urandom_range(0, 20));
                    step();
                end
                ld_start = 1'($urandom);
                w = $urandom;
                send_word(w, 1'(k == len - 1));
                ld_start = 1'b0;
            end
            wait_run(hi);
            check("rand_hold", 32'(hi), 32'd5);
            repeat ($urandom_range(5, 15)) begin
                ld_valid = 1'($urandom); ld_data = $urandom;
                if ($urandom_range(0, 9) == 0) pc = $urandom;
                else pc = BASE - 32'd8 + 32'($urandom_range(0, 36));
                step();
            end
            ld_valid = 1'b0;
        end

        step();
        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
